// File: rtl/itu656_ycrcb_unpack_pkg.sv
// Shared constants and types for the BT.656 unpacker: preamble bytes,
// XY bit positions, byte-phase and FSM encodings, and the protection helper.
package itu656_ycrcb_unpack_pkg;

  localparam logic [7:0] PREAMBLE_FF = 8'hFF;
  localparam logic [7:0] PREAMBLE_00 = 8'h00;

  localparam int XY_F = 6;
  localparam int XY_V = 5;
  localparam int XY_H = 4;

  typedef enum logic [1:0] {
    PH_CB = 2'd0,
    PH_Y0 = 2'd1,
    PH_CR = 2'd2,
    PH_Y1 = 2'd3
  } phase_t;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Protection nibble a well-formed XY byte must carry for a given F/V/H.
  function automatic logic [3:0] expected_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/itu656_ycrcb_unpack_if.sv
// Byte-stream in / 4:4:4 pixel bus out. The master side is the decoder plus
// the frame-buffer writer; the slave side is the unpacker itself.
interface itu656_ycrcb_unpack_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9
) ();

  logic [7:0]         data_in;
  logic               data_valid;
  logic [7:0]         y;
  logic [7:0]         cb;
  logic [7:0]         cr;
  logic               pixel_valid;
  logic               line_start;
  logic               frame_start;
  logic               field;
  logic [X_WIDTH-1:0] pixel_x;
  logic [Y_WIDTH-1:0] line_y;
  logic               code_error;

  modport master (
    output data_in, data_valid,
    input  y, cb, cr, pixel_valid, line_start, frame_start, field,
           pixel_x, line_y, code_error
  );

  modport slave (
    input  data_in, data_valid,
    output y, cb, cr, pixel_valid, line_start, frame_start, field,
           pixel_x, line_y, code_error
  );

endinterface

// File: rtl/itu656_timing_detect.sv
// Spots FF 00 00 XY timing codes in the accepted byte stream. The code flags
// are combinational on the XY byte so the parent can act on it in the same
// cycle; only the preamble progress is registered.
module itu656_timing_detect
  import itu656_ycrcb_unpack_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       code_valid,
  output logic       f,
  output logic       v,
  output logic       h,
  output logic       prot_ok,
  output logic       ff_seen
);

  logic [1:0] match_cnt;
  logic       is_ff;

  // Decode the current byte against the preamble progress.
  always_comb begin
    is_ff      = (data_in == PREAMBLE_FF);
    ff_seen    = data_valid && is_ff;
    code_valid = data_valid && (match_cnt == 2'd3) && !is_ff;
    f          = data_in[XY_F];
    v          = data_in[XY_V];
    h          = data_in[XY_H];
    prot_ok    = (data_in[3:0] == expected_prot(data_in[XY_F], data_in[XY_V], data_in[XY_H]));
  end

  // Track how much of FF 00 00 has been matched; any FF restarts the preamble.
  always_ff @(posedge clock) begin
    if (reset) begin
      match_cnt <= 2'd0;
    end else if (data_valid) begin
      if (is_ff)
        match_cnt <= 2'd1;
      else if ((match_cnt == 2'd1 || match_cnt == 2'd2) && data_in == PREAMBLE_00)
        match_cnt <= match_cnt + 2'd1;
      else
        match_cnt <= 2'd0;
    end
  end

endmodule

// File: rtl/itu656_ycrcb_unpack.sv
// BT.656 byte stream to 4:4:4 pixels with coordinates and frame/line markers.
// Chroma from each Cb Y0 Cr Y1 group is shared by both luma samples.
module itu656_ycrcb_unpack
  import itu656_ycrcb_unpack_pkg::*;
#(
  parameter int CHECK_PROT = 1,
  parameter int MAX_PIXELS = 720,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  itu656_ycrcb_unpack_if.slave  bus
);

  localparam logic              CHECK_EN = (CHECK_PROT != 0);
  localparam logic [X_WIDTH:0]  MAX_X    = (X_WIDTH + 1)'(MAX_PIXELS);

  logic code_valid, xy_f, xy_v, xy_h, prot_ok, ff_seen;

  itu656_timing_detect u_detect (
    .clock      (clock),
    .reset      (reset),
    .data_in    (bus.data_in),
    .data_valid (bus.data_valid),
    .code_valid (code_valid),
    .f          (xy_f),
    .v          (xy_v),
    .h          (xy_h),
    .prot_ok    (prot_ok),
    .ff_seen    (ff_seen)
  );

  state_t             state;
  phase_t             phase;
  logic [7:0]         cb_hold;
  logic [7:0]         y0_hold;
  logic [7:0]         cr_hold;
  logic [X_WIDTH-1:0] x_count;
  logic               seen_vblank;
  logic               frame_pending;
  logic               line_has_pixel;

  logic [7:0]         y_r;
  logic [7:0]         cb_r;
  logic [7:0]         cr_r;
  logic               pv_r;
  logic               ls_r;
  logic               fs_r;
  logic               field_r;
  logic [X_WIDTH-1:0] px_r;
  logic [Y_WIDTH-1:0] ly_r;
  logic               cerr_r;

  logic               code_bad;
  logic               is_data;
  logic               room;
  logic               emit_now;
  logic [7:0]         emit_y;
  logic [7:0]         emit_cr;

  // Classify the accepted byte and work out whether it completes a pixel.
  always_comb begin
    code_bad = code_valid && CHECK_EN && !prot_ok;
    is_data  = bus.data_valid && !code_valid && !ff_seen && (state == ST_ACTIVE);
    room     = ({1'b0, x_count} < MAX_X);
    emit_now = is_data && room && (phase == PH_CR || phase == PH_Y1);
    emit_y   = (phase == PH_CR) ? y0_hold : bus.data_in;
    emit_cr  = (phase == PH_CR) ? bus.data_in : cr_hold;
  end

  // Line FSM, byte-phase tracking, counters and registered pixel outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_SEARCH;
      phase          <= PH_CB;
      cb_hold        <= '0;
      y0_hold        <= '0;
      cr_hold        <= '0;
      x_count        <= '0;
      seen_vblank    <= 1'b1;
      frame_pending  <= 1'b0;
      line_has_pixel <= 1'b0;
      y_r            <= '0;
      cb_r           <= '0;
      cr_r           <= '0;
      pv_r           <= 1'b0;
      ls_r           <= 1'b0;
      fs_r           <= 1'b0;
      field_r        <= 1'b0;
      px_r           <= '0;
      ly_r           <= '0;
      cerr_r         <= 1'b0;
    end else begin
      pv_r   <= 1'b0;
      ls_r   <= 1'b0;
      fs_r   <= 1'b0;
      cerr_r <= 1'b0;
      if (bus.data_valid) begin
        if (code_valid) begin
          if (code_bad) begin
            cerr_r <= 1'b1;
          end else if (!xy_h) begin
            if (!xy_v) begin
              state          <= ST_ACTIVE;
              phase          <= PH_CB;
              x_count        <= '0;
              line_has_pixel <= 1'b0;
              field_r        <= xy_f;
              frame_pending  <= seen_vblank && !xy_f;
              seen_vblank    <= 1'b0;
              if (seen_vblank)
                ly_r <= '0;
            end else begin
              state       <= ST_SEARCH;
              seen_vblank <= 1'b1;
            end
          end else begin
            state          <= ST_SEARCH;
            line_has_pixel <= 1'b0;
            if (line_has_pixel)
              ly_r <= ly_r + 1'b1;
          end
        end else if (ff_seen) begin
          state <= ST_SEARCH;
        end else if (state == ST_ACTIVE) begin
          phase <= phase_t'(phase + 2'd1);
          case (phase)
            PH_CB:   cb_hold <= bus.data_in;
            PH_Y0:   y0_hold <= bus.data_in;
            PH_CR:   cr_hold <= bus.data_in;
            default: ;
          endcase
          if (emit_now) begin
            y_r            <= emit_y;
            cb_r           <= cb_hold;
            cr_r           <= emit_cr;
            pv_r           <= 1'b1;
            px_r           <= x_count;
            ls_r           <= (x_count == '0);
            fs_r           <= frame_pending && (x_count == '0);
            frame_pending  <= 1'b0;
            x_count        <= x_count + 1'b1;
            line_has_pixel <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.y           = y_r;
  assign bus.cb          = cb_r;
  assign bus.cr          = cr_r;
  assign bus.pixel_valid = pv_r;
  assign bus.line_start  = ls_r;
  assign bus.frame_start = fs_r;
  assign bus.field       = field_r;
  assign bus.pixel_x     = px_r;
  assign bus.line_y      = ly_r;
  assign bus.code_error  = cerr_r;

endmodule

// File: tb/tb_itu656_ycrcb_unpack.sv
// Directed bench for the BT.656 unpacker: a table of byte vectors with
// hand-computed pixels, plus sequences for pixel truncation and mid-line reset.
module tb_itu656_ycrcb_unpack;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       pv;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic [9:0] x;
    logic [8:0] ly;
    logic       ls;
    logic       fs;
    logic       fld;
    logic       ce;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din   = 8'h00;
  logic       dv    = 1'b0;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   cnt_main = 0;
  int   cnt4     = 0;
  int   max4     = 0;

  always #5 clock = ~clock;

  itu656_ycrcb_unpack_if #(.X_WIDTH(10), .Y_WIDTH(9)) bus  ();
  itu656_ycrcb_unpack_if #(.X_WIDTH(10), .Y_WIDTH(9)) bus4 ();

  assign bus.data_in     = din;
  assign bus.data_valid  = dv;
  assign bus4.data_in    = din;
  assign bus4.data_valid = dv;

  itu656_ycrcb_unpack #(.CHECK_PROT(1), .MAX_PIXELS(720), .X_WIDTH(10), .Y_WIDTH(9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  itu656_ycrcb_unpack #(.CHECK_PROT(1), .MAX_PIXELS(4), .X_WIDTH(10), .Y_WIDTH(9)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addByte(input logic [7:0] d, input logic v);
    vec_t e;
    e = '{d: d, v: v, pv: 1'b0, y: 8'h00, cb: 8'h00, cr: 8'h00, x: 10'd0,
          ly: 9'd0, ls: 1'b0, fs: 1'b0, fld: 1'b0, ce: 1'b0};
    tbl.push_back(e);
  endtask

  task automatic addCode(input logic [7:0] xy, input logic ce);
    vec_t e;
    addByte(8'hFF, 1'b1);
    addByte(8'h00, 1'b1);
    addByte(8'h00, 1'b1);
    e = '{d: xy, v: 1'b1, pv: 1'b0, y: 8'h00, cb: 8'h00, cr: 8'h00, x: 10'd0,
          ly: 9'd0, ls: 1'b0, fs: 1'b0, fld: 1'b0, ce: ce};
    tbl.push_back(e);
  endtask

  task automatic addPix(input logic [7:0] d, input logic [7:0] y, input logic [7:0] cb,
                        input logic [7:0] cr, input logic [9:0] x, input logic [8:0] ly,
                        input logic ls, input logic fs, input logic fld);
    vec_t e;
    e = '{d: d, v: 1'b1, pv: 1'b1, y: y, cb: cb, cr: cr, x: x,
          ly: ly, ls: ls, fs: fs, fld: fld, ce: 1'b0};
    tbl.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t e);
    din = e.d;
    dv  = e.v;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input vec_t e, input int idx);
    n_vec++;
    cmp($sformatf("v%0d pixel_valid", idx), 32'(bus.pixel_valid), 32'(e.pv));
    cmp($sformatf("v%0d code_error", idx), 32'(bus.code_error), 32'(e.ce));
    if (e.pv) begin
      cmp($sformatf("v%0d y", idx), 32'(bus.y), 32'(e.y));
      cmp($sformatf("v%0d cb", idx), 32'(bus.cb), 32'(e.cb));
      cmp($sformatf("v%0d cr", idx), 32'(bus.cr), 32'(e.cr));
      cmp($sformatf("v%0d pixel_x", idx), 32'(bus.pixel_x), 32'(e.x));
      cmp($sformatf("v%0d line_y", idx), 32'(bus.line_y), 32'(e.ly));
      cmp($sformatf("v%0d line_start", idx), 32'(bus.line_start), 32'(e.ls));
      cmp($sformatf("v%0d frame_start", idx), 32'(bus.frame_start), 32'(e.fs));
      cmp($sformatf("v%0d field", idx), 32'(bus.field), 32'(e.fld));
    end
  endtask

  task automatic runVectors();
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], i);
    end
    tbl.delete();
    dv = 1'b0;
  endtask

  task automatic step(input logic [7:0] d, input logic v);
    din = d;
    dv  = v;
    @(posedge clock);
    #1;
    if (bus.pixel_valid) cnt_main++;
    if (bus4.pixel_valid) begin
      cnt4++;
      if (int'(bus4.pixel_x) > max4) max4 = int'(bus4.pixel_x);
    end
  endtask

  task automatic checkAllZero(input string tag);
    n_vec++;
    cmp({tag, " y"}, 32'(bus.y), 32'd0);
    cmp({tag, " cb"}, 32'(bus.cb), 32'd0);
    cmp({tag, " cr"}, 32'(bus.cr), 32'd0);
    cmp({tag, " pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
    cmp({tag, " line_start"}, 32'(bus.line_start), 32'd0);
    cmp({tag, " frame_start"}, 32'(bus.frame_start), 32'd0);
    cmp({tag, " field"}, 32'(bus.field), 32'd0);
    cmp({tag, " pixel_x"}, 32'(bus.pixel_x), 32'd0);
    cmp({tag, " line_y"}, 32'(bus.line_y), 32'd0);
    cmp({tag, " code_error"}, 32'(bus.code_error), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    dv    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Field 0, first active line after vertical blanking.
    addCode(8'hAB, 1'b0);
    addCode(8'h80, 1'b0);
    addByte(8'h80, 1'b1);
    addByte(8'h10, 1'b1);
    addPix(8'hF0, 8'h10, 8'h80, 8'hF0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0);
    addPix(8'h20, 8'h20, 8'h80, 8'hF0, 10'd1, 9'd0, 1'b0, 1'b0, 1'b0);
    addByte(8'h80, 1'b1);
    addByte(8'h30, 1'b1);
    addPix(8'hF0, 8'h30, 8'h80, 8'hF0, 10'd2, 9'd0, 1'b0, 1'b0, 1'b0);
    addPix(8'h40, 8'h40, 8'h80, 8'hF0, 10'd3, 9'd0, 1'b0, 1'b0, 1'b0);
    addCode(8'h9D, 1'b0);
    // Second line: line_y advances, no frame_start.
    addCode(8'h80, 1'b0);
    addByte(8'h11, 1'b1);
    addByte(8'h22, 1'b1);
    addPix(8'h33, 8'h22, 8'h11, 8'h33, 10'd0, 9'd1, 1'b1, 1'b0, 1'b0);
    addPix(8'h44, 8'h44, 8'h11, 8'h33, 10'd1, 9'd1, 1'b0, 1'b0, 1'b0);
    addCode(8'h9D, 1'b0);
    // Stalls inside a group, including a stalled FF that must be ignored.
    addCode(8'h80, 1'b0);
    addByte(8'h12, 1'b1);
    addByte(8'hFF, 1'b0);
    addByte(8'h34, 1'b1);
    addByte(8'h00, 1'b0);
    addPix(8'h56, 8'h34, 8'h12, 8'h56, 10'd0, 9'd2, 1'b1, 1'b0, 1'b0);
    addByte(8'h99, 1'b0);
    addPix(8'h78, 8'h78, 8'h12, 8'h56, 10'd1, 9'd2, 1'b0, 1'b0, 1'b0);
    addCode(8'h9D, 1'b0);
    // Truncated trailing group: Cb,Y0 then EAV produce nothing.
    addCode(8'h80, 1'b0);
    addByte(8'hAA, 1'b1);
    addByte(8'hBB, 1'b1);
    addPix(8'hCC, 8'hBB, 8'hAA, 8'hCC, 10'd0, 9'd3, 1'b1, 1'b0, 1'b0);
    addPix(8'hDD, 8'hDD, 8'hAA, 8'hCC, 10'd1, 9'd3, 1'b0, 1'b0, 1'b0);
    addByte(8'hEE, 1'b1);
    addByte(8'h01, 1'b1);
    addCode(8'h9D, 1'b0);
    addCode(8'h80, 1'b0);
    addByte(8'h10, 1'b1);
    addByte(8'h20, 1'b1);
    addPix(8'h30, 8'h20, 8'h10, 8'h30, 10'd0, 9'd4, 1'b1, 1'b0, 1'b0);
    addPix(8'h40, 8'h40, 8'h10, 8'h30, 10'd1, 9'd4, 1'b0, 1'b0, 1'b0);
    addCode(8'h9D, 1'b0);
    // Vertical blanking restarts line count and raises frame_start again.
    addCode(8'hB6, 1'b0);
    addCode(8'hAB, 1'b0);
    addCode(8'h80, 1'b0);
    addByte(8'h21, 1'b1);
    addByte(8'h22, 1'b1);
    addPix(8'h23, 8'h22, 8'h21, 8'h23, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0);
    addPix(8'h24, 8'h24, 8'h21, 8'h23, 10'd1, 9'd0, 1'b0, 1'b0, 1'b0);
    addCode(8'h9D, 1'b0);
    // Bad protection: error pulse, FSM stays in SEARCH so data is ignored.
    addCode(8'h81, 1'b1);
    addByte(8'h55, 1'b1);
    addByte(8'h55, 1'b1);
    addByte(8'h55, 1'b1);
    addByte(8'h55, 1'b1);
    // Field 1 line.
    addCode(8'hC7, 1'b0);
    addByte(8'h01, 1'b1);
    addByte(8'h02, 1'b1);
    addPix(8'h03, 8'h02, 8'h01, 8'h03, 10'd0, 9'd1, 1'b1, 1'b0, 1'b1);
    addPix(8'h04, 8'h04, 8'h01, 8'h03, 10'd1, 9'd1, 1'b0, 1'b0, 1'b1);
    addCode(8'hDA, 1'b0);
    runVectors();

    // Four groups on one line: the MAX_PIXELS=4 instance keeps only four pixels.
    cnt_main = 0;
    cnt4     = 0;
    max4     = 0;
    step(8'hFF, 1'b1); step(8'h00, 1'b1); step(8'h00, 1'b1); step(8'h80, 1'b1);
    for (int g = 0; g < 4; g++) begin
      step(8'h01, 1'b1); step(8'h02, 1'b1); step(8'h03, 1'b1); step(8'h04, 1'b1);
    end
    step(8'hFF, 1'b1); step(8'h00, 1'b1); step(8'h00, 1'b1); step(8'h9D, 1'b1);
    dv = 1'b0;
    n_vec++;
    cmp("max main pixel count", 32'(cnt_main), 32'd8);
    n_vec++;
    cmp("max limited pixel count", 32'(cnt4), 32'd4);
    n_vec++;
    cmp("max limited pixel_x", 32'(max4), 32'd3);

    // Reset after Y0 of a group: outputs clear, nothing until the next SAV.
    addCode(8'h80, 1'b0);
    addByte(8'h80, 1'b1);
    addByte(8'h10, 1'b1);
    runVectors();
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkAllZero("midreset");
    reset = 1'b0;
    addByte(8'hF0, 1'b1);
    addByte(8'h20, 1'b1);
    addCode(8'h80, 1'b0);
    addByte(8'h80, 1'b1);
    addByte(8'h10, 1'b1);
    addPix(8'hF0, 8'h10, 8'h80, 8'hF0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0);
    addPix(8'h20, 8'h20, 8'h80, 8'hF0, 10'd1, 9'd0, 1'b0, 1'b0, 1'b0);
    runVectors();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
